// File: rtl/aes_ex_loader_if.sv
// Signal bundle between the ID/EX AES control fields, the AES core and the writeback path.
// The slave modport is the loader's view; the master modport is the upstream/core side.
interface aes_ex_loader_if;
    logic         enable_aes_in;
    logic         aes_w_in;
    logic [1:0]   key_size_in;
    logic [1:0]   mode_aes_in;
    logic [31:0]  w2_in;
    logic [31:0]  re_adder_32_in;
    logic         plus1_in;
    logic         aes_done_in;
    logic [127:0] aes_result_in;
    logic         aes_start_out;
    logic         aes_decrypt_out;
    logic [1:0]   aes_key_size_out;
    logic [255:0] aes_key_out;
    logic [127:0] aes_block_out;
    logic         stall_out;
    logic [31:0]  rd_data_out;
    logic         rd_valid_out;
    logic         err_out;

    modport slave (
        input  enable_aes_in, aes_w_in, key_size_in, mode_aes_in, w2_in,
               re_adder_32_in, plus1_in, aes_done_in, aes_result_in,
        output aes_start_out, aes_decrypt_out, aes_key_size_out, aes_key_out,
               aes_block_out, stall_out, rd_data_out, rd_valid_out, err_out
    );

    modport master (
        output enable_aes_in, aes_w_in, key_size_in, mode_aes_in, w2_in,
               re_adder_32_in, plus1_in, aes_done_in, aes_result_in,
        input  aes_start_out, aes_decrypt_out, aes_key_size_out, aes_key_out,
               aes_block_out, stall_out, rd_data_out, rd_valid_out, err_out
    );
endinterface

// File: rtl/aes_ex_loader.sv
// Execute-stage AES loader: assembles key/data words, launches the core, stalls while busy, returns result words.
// Defining AES_LOADER_TIMEOUT_EN adds a BUSY watchdog that aborts after TIMEOUT_CYCLES cycles.
module aes_ex_loader #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic            clk,
    input logic            reset,
    aes_ex_loader_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;

    localparam logic [1:0] OP_KEY  = 2'b00;
    localparam logic [1:0] OP_DATA = 2'b01;

    logic [1:0]  state;
    logic [31:0] key_buf [8];
    logic [31:0] data_buf [4];
    logic [31:0] res_buf [4];
    logic [2:0]  key_ptr;
    logic [1:0]  data_ptr;
    logic        start;
    logic        decrypt;
    logic [1:0]  key_size;
    logic        err;
    logic        rd_valid;
    logic [31:0] rd_data;

    logic        accept;
    logic [3:0]  nk;
    logic [2:0]  key_tgt;
    logic [1:0]  data_tgt;
    logic        key_ok;
    logic [2:0]  key_ptr_next;
    logic        unused_idx_bits;

    assign accept = bus.enable_aes_in && (state == ST_IDLE);

    // Key length in words for the size carried by the current op; the illegal size allows no key words.
    always_comb begin
        nk = 4'd0;
        case (bus.key_size_in)
            2'b00:   nk = 4'd4;
            2'b01:   nk = 4'd6;
            2'b10:   nk = 4'd8;
            default: nk = 4'd0;
        endcase
    end

    assign key_tgt         = bus.plus1_in ? key_ptr : bus.re_adder_32_in[2:0];
    assign data_tgt        = bus.plus1_in ? data_ptr : bus.re_adder_32_in[1:0];
    assign key_ok          = ({1'b0, key_tgt} < nk);
    assign key_ptr_next    = (({1'b0, key_ptr} + 4'd1) >= nk) ? 3'd0 : key_ptr + 3'd1;
    assign unused_idx_bits = ^bus.re_adder_32_in[31:3];

`ifdef AES_LOADER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] busy_cnt;
    logic             timeout;

    assign timeout = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || state != ST_BUSY)
            busy_cnt <= '0;
        else
            busy_cnt <= busy_cnt + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            key_ptr  <= 3'd0;
            data_ptr <= 2'd0;
            start    <= 1'b0;
            decrypt  <= 1'b0;
            key_size <= 2'b00;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 32'h0;
            for (int i = 0; i < 8; i++) key_buf[i] <= 32'h0;
            for (int i = 0; i < 4; i++) begin
                data_buf[i] <= 32'h0;
                res_buf[i]  <= 32'h0;
            end
        end else begin
            start    <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && bus.aes_w_in) begin
                        case (bus.mode_aes_in)
                            OP_KEY: begin
                                if (key_ok) key_buf[key_tgt] <= bus.w2_in;
                                else        err <= 1'b1;
                                if (bus.plus1_in) key_ptr <= key_ptr_next;
                            end
                            OP_DATA: begin
                                data_buf[data_tgt] <= bus.w2_in;
                                if (bus.plus1_in) data_ptr <= data_ptr + 2'd1;
                            end
                            default: begin
                                if (bus.key_size_in != 2'b11) begin
                                    decrypt  <= bus.mode_aes_in[0];
                                    key_size <= bus.key_size_in;
                                    key_ptr  <= 3'd0;
                                    data_ptr <= 2'd0;
                                    start    <= 1'b1;
                                    state    <= ST_LAUNCH;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                        endcase
                    end else if (accept) begin
                        rd_data  <= res_buf[bus.re_adder_32_in[1:0]];
                        rd_valid <= 1'b1;
                    end
                end
                // LAUNCH lasts one cycle; a done seen there or in BUSY finishes the operation.
                ST_LAUNCH, ST_BUSY: begin
                    if (bus.aes_done_in) begin
                        for (int i = 0; i < 4; i++) res_buf[i] <= bus.aes_result_in[127 - 32*i -: 32];
                        state <= ST_IDLE;
                    end
`ifdef AES_LOADER_TIMEOUT_EN
                    else if (state == ST_BUSY && timeout) begin
                        for (int i = 0; i < 4; i++) res_buf[i] <= 32'h0;
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end
`endif
                    else begin
                        state <= ST_BUSY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.aes_start_out    = start;
    assign bus.aes_decrypt_out  = decrypt;
    assign bus.aes_key_size_out = key_size;
    assign bus.aes_key_out      = {key_buf[0], key_buf[1], key_buf[2], key_buf[3],
                                   key_buf[4], key_buf[5], key_buf[6], key_buf[7]};
    assign bus.aes_block_out    = {data_buf[0], data_buf[1], data_buf[2], data_buf[3]};
    assign bus.stall_out        = (state != ST_IDLE);
    assign bus.rd_data_out      = rd_data;
    assign bus.rd_valid_out     = rd_valid;
    assign bus.err_out          = err;
endmodule

// File: tb/tb_aes_ex_loader.sv
// Randomized scoreboard bench for aes_ex_loader against a word-level behavioural model.
// Define AES_LOADER_TIMEOUT_EN for both bench and RTL to also exercise the BUSY watchdog.
module tb_aes_ex_loader;
    localparam int TO_CYCLES = 8;
    localparam logic [1:0] MODE_KEY  = 2'b00;
    localparam logic [1:0] MODE_DATA = 2'b01;
    localparam logic [1:0] MODE_ENC  = 2'b10;
    localparam logic [1:0] MODE_DEC  = 2'b11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_ex_loader_if bus ();
    aes_ex_loader #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Behavioural model: word arrays, pointers and flags as the loader is described.
    logic [31:0] m_key [8];
    logic [31:0] m_data [4];
    logic [31:0] m_res [4];
    int          m_kptr;
    int          m_dptr;
    logic        m_err;
    logic        m_dec;
    logic [1:0]  m_ks;
    logic [31:0] exp_q [$];

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) m_key[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            m_data[i] = 32'h0;
            m_res[i]  = 32'h0;
        end
        m_kptr = 0;
        m_dptr = 0;
        m_err  = 1'b0;
        m_dec  = 1'b0;
        m_ks   = 2'b00;
    endfunction

    function automatic void modelOp(input logic w, input logic [1:0] ks, input logic [1:0] mode,
                                    input logic [31:0] word, input logic [31:0] idx, input logic p1);
        int nk;
        int tgt;
        nk = (ks == 2'b00) ? 4 : (ks == 2'b01) ? 6 : (ks == 2'b10) ? 8 : 0;
        if (!w) begin
            exp_q.push_back(m_res[idx[1:0]]);
        end else if (mode == MODE_KEY) begin
            tgt = p1 ? m_kptr : int'(idx[2:0]);
            if (tgt < nk) m_key[tgt] = word;
            else          m_err = 1'b1;
            if (p1) m_kptr = (nk == 0) ? 0 : (m_kptr + 1) % nk;
        end else if (mode == MODE_DATA) begin
            tgt = p1 ? m_dptr : int'(idx[1:0]);
            m_data[tgt] = word;
            if (p1) m_dptr = (m_dptr + 1) % 4;
        end else if (ks == 2'b11) begin
            m_err = 1'b1;
        end else begin
            m_kptr = 0;
            m_dptr = 0;
            m_dec  = mode[0];
            m_ks   = ks;
        end
    endfunction

    function automatic logic [255:0] expKey();
        return {m_key[0], m_key[1], m_key[2], m_key[3], m_key[4], m_key[5], m_key[6], m_key[7]};
    endfunction

    function automatic logic [127:0] expBlock();
        return {m_data[0], m_data[1], m_data[2], m_data[3]};
    endfunction

    // Present one op and hold it until the loader is idle; returns just after the accepting edge.
    task automatic applyStimulus(input logic w, input logic [1:0] ks, input logic [1:0] mode,
                                 input logic [31:0] word, input logic [31:0] idx, input logic p1,
                                 output bit ok);
        int waited;
        @(negedge clk);
        bus.aes_w_in       = w;
        bus.key_size_in    = ks;
        bus.mode_aes_in    = mode;
        bus.w2_in          = word;
        bus.re_adder_32_in = idx;
        bus.plus1_in       = p1;
        bus.enable_aes_in  = 1'b1;
        waited = 0;
        while (bus.stall_out !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: stall_out %b after %0d cycles, required 0", bus.stall_out, waited);
            bus.enable_aes_in = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        modelOp(w, ks, mode, word, idx, p1);
        #1;
        bus.enable_aes_in = 1'b0;
        ok = 1'b1;
    endtask

    task automatic writeAndCheck(input logic [1:0] ks, input logic [1:0] mode, input logic [31:0] word,
                                 input logic [31:0] idx, input logic p1);
        bit ok;
        applyStimulus(1'b1, ks, mode, word, idx, p1, ok);
        @(negedge clk);
        checkOutput("key_out", bus.aes_key_out, expKey());
        checkOutput("block_out", 256'(bus.aes_block_out), 256'(expBlock()));
        checkOutput("err_out", 256'(bus.err_out), 256'(m_err));
    endtask

    task automatic pulseDone(input int k, input logic [127:0] res, input bit capture);
        repeat (k) @(negedge clk);
        bus.aes_result_in = res;
        bus.aes_done_in   = 1'b1;
        if (capture) for (int i = 0; i < 4; i++) m_res[i] = res[127 - 32*i -: 32];
        @(negedge clk);
        bus.aes_done_in = 1'b0;
    endtask

    // Launch, deliver done so it is sampled k edges after acceptance, optionally present a read alongside done.
    task automatic runLaunch(input logic [1:0] ks, input logic dec, input int k, input logic [127:0] res,
                             input int rd_idx);
        int  stalls;
        int  starts;
        bit  ok;
        bit  ok2;
        applyStimulus(1'b1, ks, dec ? MODE_DEC : MODE_ENC, 32'h0, 32'h0, 1'b0, ok);
        if (!ok) return;
        stalls = 0;
        starts = 0;
        fork
            pulseDone(k, res, 1'b1);
            begin
                for (int n = 0; n < 300; n++) begin
                    @(negedge clk);
                    if (bus.aes_start_out) starts++;
                    if (!bus.stall_out) break;
                    stalls++;
                end
            end
            begin
                if (rd_idx >= 0) begin
                    repeat (k - 1) @(negedge clk);
                    applyStimulus(1'b0, 2'b00, 2'b00, 32'(rd_idx), 32'(rd_idx), 1'b0, ok2);
                end
            end
        join
        checkOutput("stall_cycles", 256'(stalls), 256'(k));
        checkOutput("start_pulses", 256'(starts), 256'(1));
        checkOutput("decrypt_out", 256'(bus.aes_decrypt_out), 256'(m_dec));
        checkOutput("key_size_out", 256'(bus.aes_key_size_out), 256'(m_ks));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_start"}, 256'(bus.aes_start_out), 256'(0));
        checkOutput({tag, "_stall"}, 256'(bus.stall_out), 256'(0));
        checkOutput({tag, "_err"}, 256'(bus.err_out), 256'(0));
        checkOutput({tag, "_rd_valid"}, 256'(bus.rd_valid_out), 256'(0));
        checkOutput({tag, "_rd_data"}, 256'(bus.rd_data_out), 256'(0));
        checkOutput({tag, "_key"}, bus.aes_key_out, 256'(0));
        checkOutput({tag, "_block"}, 256'(bus.aes_block_out), 256'(0));
        checkOutput({tag, "_decrypt"}, 256'(bus.aes_decrypt_out), 256'(0));
        checkOutput({tag, "_key_size"}, 256'(bus.aes_key_size_out), 256'(0));
    endtask

    // Monitor: every read response is compared against the oldest expected word.
    initial begin
        forever begin : mon
            logic [31:0] e;
            @(negedge clk);
            if (bus.rd_valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_read: rd_valid_out 1 data %h, no read outstanding", bus.rd_data_out);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rd_data", 256'(bus.rd_data_out), 256'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          ok;
        int          starts;
        int          stalls;
        logic [1:0]  ks;
        logic [1:0]  mode;
        logic [127:0] res;
        int          nw;
        int          rd_idx;

        bus.enable_aes_in  = 1'b0;
        bus.aes_w_in       = 1'b0;
        bus.key_size_in    = 2'b00;
        bus.mode_aes_in    = 2'b00;
        bus.w2_in          = 32'h0;
        bus.re_adder_32_in = 32'h0;
        bus.plus1_in       = 1'b0;
        bus.aes_done_in    = 1'b0;
        bus.aes_result_in  = 128'h0;
        reset = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;

        // AES-128 key via auto-increment, then a fifth write that wraps to kw0.
        writeAndCheck(2'b00, MODE_KEY, 32'h2b7e1516, 32'h0, 1'b1);
        writeAndCheck(2'b00, MODE_KEY, 32'h28aed2a6, 32'h0, 1'b1);
        writeAndCheck(2'b00, MODE_KEY, 32'habf71588, 32'h0, 1'b1);
        writeAndCheck(2'b00, MODE_KEY, 32'h09cf4f3c, 32'h0, 1'b1);
        checkOutput("key128_hi", 256'(bus.aes_key_out[255:128]), 256'(128'h2b7e151628aed2a6abf7158809cf4f3c));
        writeAndCheck(2'b00, MODE_KEY, 32'h11111111, 32'h0, 1'b1);
        checkOutput("key_wrap_kw0", 256'(bus.aes_key_out[255:224]), 256'(32'h11111111));
        writeAndCheck(2'b00, MODE_DATA, 32'h3243f6a8, 32'h0, 1'b1);
        writeAndCheck(2'b00, MODE_DATA, 32'h885a308d, 32'h3, 1'b0);

        runLaunch(2'b00, 1'b0, 11, 128'h3925841d02dc09fbdc118597196a0b32, -1);
        applyStimulus(1'b0, 2'b00, 2'b00, 32'h0, 32'h2, 1'b0, ok);

        // Read presented in the same cycle as done: accepted after stall drops, returns new data.
        runLaunch(2'b00, 1'b1, 5, 128'h0123456789abcdeffedcba9876543210, 0);

        // Error cases: out-of-range key index and illegal key size on launch.
        writeAndCheck(2'b00, MODE_KEY, 32'hcafef00d, 32'h6, 1'b0);
        checkOutput("err_bad_index", 256'(bus.err_out), 256'(1));
        applyStimulus(1'b1, 2'b11, MODE_ENC, 32'h0, 32'h0, 1'b0, ok);
        starts = 0;
        stalls = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.aes_start_out) starts++;
            if (bus.stall_out) stalls++;
        end
        checkOutput("illegal_launch_start", 256'(starts), 256'(0));
        checkOutput("illegal_launch_stall", 256'(stalls), 256'(0));
        checkOutput("illegal_launch_err", 256'(bus.err_out), 256'(m_err));

        // Reset for two cycles in the middle of BUSY; a late done must be ignored.
        applyStimulus(1'b1, 2'b00, MODE_ENC, 32'h0, 32'h0, 1'b0, ok);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midbusy_reset");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        pulseDone(0, 128'hffffffff_eeeeeeee_dddddddd_cccccccc, 1'b0);
        checkOutput("post_reset_stall", 256'(bus.stall_out), 256'(0));
        applyStimulus(1'b0, 2'b00, 2'b00, 32'h0, 32'h1, 1'b0, ok);

        // Randomized rounds: key size fixed per round so the key pointer stays within the key.
        for (int r = 0; r < 24; r++) begin
            ks = 2'($urandom_range(0, 2));
            nw = $urandom_range(3, 9);
            for (int j = 0; j < nw; j++) begin
                mode = ($urandom_range(0, 1) == 1) ? MODE_DATA : MODE_KEY;
                writeAndCheck(ks, mode, $urandom, 32'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            res = {$urandom, $urandom, $urandom, $urandom};
            rd_idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
            runLaunch(ks, 1'($urandom_range(0, 1)), $urandom_range(1, 12), res, rd_idx);
            applyStimulus(1'b0, 2'b00, 2'b00, 32'h0, 32'($urandom_range(0, 3)), 1'b0, ok);
        end

`ifdef AES_LOADER_TIMEOUT_EN
        // No done ever arrives: one LAUNCH cycle plus TO_CYCLES BUSY cycles, then abort.
        applyStimulus(1'b1, 2'b00, MODE_ENC, 32'h0, 32'h0, 1'b0, ok);
        stalls = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!bus.stall_out) break;
            stalls++;
        end
        m_err = 1'b1;
        for (int i = 0; i < 4; i++) m_res[i] = 32'h0;
        checkOutput("timeout_stall_cycles", 256'(stalls), 256'(TO_CYCLES + 1));
        checkOutput("timeout_err", 256'(bus.err_out), 256'(m_err));
        applyStimulus(1'b0, 2'b00, 2'b00, 32'h0, 32'h3, 1'b0, ok);
`endif

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
